// File: rtl/dsp48a1_seq_pkg.sv
// Shared types and constants for the DSP48A1 dot-product job sequencer.
// Slice widths and the two OPMODE encodings the sequencer ever drives.
package dsp48a1_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FEED  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } seq_state_e;

   localparam int DSP_AB_W = 18;
   localparam int DSP_P_W  = 48;

   // X=M, Z=0: restart the accumulation from the current product.
   localparam logic [7:0] OPM_MUL = 8'h01;
   // X=M, Z=P: add the current product to the running sum.
   localparam logic [7:0] OPM_MAC = 8'h09;

endpackage

// File: rtl/dsp48a1_mac_sequencer.sv
// Dot-product job controller driving one fully-pipelined DSP48A1 slice.
// Feeds (a,b) beats, drains the pipeline, and returns P on a valid/ready port.
module dsp48a1_mac_sequencer
   import dsp48a1_seq_pkg::*;
#(
   parameter int LEN_W   = 8,
   parameter int DSP_LAT = 4,
   parameter int OPM_LAG = 2
) (
   input  logic                       CLK,
   input  logic                       RST_N,
   input  logic                       start,
   input  logic [LEN_W-1:0]           len,
   output logic                       busy,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic signed [DSP_AB_W-1:0] s_a,
   input  logic signed [DSP_AB_W-1:0] s_b,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic signed [DSP_P_W-1:0]  result,
   output logic signed [DSP_AB_W-1:0] dsp_a,
   output logic signed [DSP_AB_W-1:0] dsp_b,
   output logic [7:0]                 dsp_opmode,
   output logic                       dsp_ce,
   output logic                       dsp_rst,
   input  logic signed [DSP_P_W-1:0]  dsp_p
);

   localparam int                 DCNT_W     = $clog2(DSP_LAT) + 1;
   localparam logic [DCNT_W-1:0]  DRAIN_LAST = DCNT_W'(DSP_LAT - 1);

   seq_state_e                  state_q, state_d;
   logic [LEN_W-1:0]            len_q, len_d;
   logic [LEN_W-1:0]            beat_cnt_q, beat_cnt_d;
   logic [DCNT_W-1:0]           drain_cnt_q, drain_cnt_d;
   logic [OPM_LAG-1:0]          first_line_q, first_line_d;
   logic                        res_valid_q, res_valid_d;
   logic signed [DSP_P_W-1:0]   result_q, result_d;
   logic                        dsp_rst_q;
   logic                        beat_acc;
   logic                        first_in;

   assign busy       = (state_q != IDLE);
   assign s_ready    = (state_q == FEED);
   assign res_valid  = res_valid_q;
   assign result     = result_q;
   assign dsp_rst    = dsp_rst_q;
   assign dsp_opmode = first_line_q[OPM_LAG-1] ? OPM_MUL : OPM_MAC;

   // Job FSM: next state, counters, result capture and slice pin drive.
   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      beat_cnt_d  = beat_cnt_q;
      drain_cnt_d = drain_cnt_q;
      res_valid_d = res_valid_q;
      result_d    = result_q;
      beat_acc    = 1'b0;
      dsp_ce      = 1'b0;
      dsp_a       = '0;
      dsp_b       = '0;
      case (state_q)
         IDLE: begin
            if (start) begin
               len_d      = len;
               beat_cnt_d = '0;
               if (len != '0) begin
                  state_d = FEED;
               end else begin
                  state_d     = DONE;
                  result_d    = '0;
                  res_valid_d = 1'b1;
               end
            end else begin
               state_d = IDLE;
            end
         end
         FEED: begin
            if (s_valid) begin
               beat_acc   = 1'b1;
               dsp_ce     = 1'b1;
               dsp_a      = s_a;
               dsp_b      = s_b;
               beat_cnt_d = beat_cnt_q + LEN_W'(1);
               if (beat_cnt_d == len_q) begin
                  state_d     = DRAIN;
                  drain_cnt_d = '0;
               end else begin
                  state_d = FEED;
               end
            end else begin
               state_d = FEED;
            end
         end
         DRAIN: begin
            // Zero beats keep the slice clocked so the last product reaches P.
            dsp_ce = 1'b1;
            if (drain_cnt_q == DRAIN_LAST) begin
               result_d    = dsp_p;
               res_valid_d = 1'b1;
               state_d     = DONE;
            end else begin
               drain_cnt_d = drain_cnt_q + DCNT_W'(1);
               state_d     = DRAIN;
            end
         end
         DONE: begin
            if (res_valid_q && res_ready) begin
               res_valid_d = 1'b0;
               if (start) begin
                  len_d      = len;
                  beat_cnt_d = '0;
                  if (len != '0) begin
                     state_d = FEED;
                  end else begin
                     state_d     = DONE;
                     result_d    = '0;
                     res_valid_d = 1'b1;
                  end
               end else begin
                  state_d = IDLE;
               end
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // First-beat marker travels with the beat so OPMODE meets its product at P.
   always_comb begin
      first_in     = beat_acc && (beat_cnt_q == '0);
      first_line_d = first_line_q;
      if (dsp_ce) begin
         first_line_d    = first_line_q << 1;
         first_line_d[0] = first_in;
      end else begin
         first_line_d = first_line_q;
      end
   end

   // State and datapath registers; the slice reset is a registered copy of RST_N.
   always_ff @(posedge CLK) begin
      dsp_rst_q <= ~RST_N;
      if (!RST_N) begin
         state_q      <= IDLE;
         len_q        <= '0;
         beat_cnt_q   <= '0;
         drain_cnt_q  <= '0;
         first_line_q <= '0;
         res_valid_q  <= 1'b0;
         result_q     <= '0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         beat_cnt_q   <= beat_cnt_d;
         drain_cnt_q  <= drain_cnt_d;
         first_line_q <= first_line_d;
         res_valid_q  <= res_valid_d;
         result_q     <= result_d;
      end
   end

endmodule

// File: tb/tb_dsp48a1_mac_sequencer.sv
// Self-checking bench: behavioural DSP48A1 slice load, job table and result scoreboard.
module tb_dsp48a1_mac_sequencer;

   logic               clk = 1'b0;
   logic               RST_N;
   logic               start;
   logic [7:0]         len;
   logic               busy;
   logic               s_valid;
   logic               s_ready;
   logic signed [17:0] s_a, s_b;
   logic               res_valid;
   logic               res_ready;
   logic signed [47:0] result;
   logic signed [17:0] dsp_a, dsp_b;
   logic [7:0]         dsp_opmode;
   logic               dsp_ce;
   logic               dsp_rst;
   logic signed [47:0] dsp_p;

   always #5 clk = ~clk;

   dsp48a1_mac_sequencer dut (
      .CLK(clk), .RST_N(RST_N), .start(start), .len(len), .busy(busy),
      .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
      .res_valid(res_valid), .res_ready(res_ready), .result(result),
      .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode),
      .dsp_ce(dsp_ce), .dsp_rst(dsp_rst), .dsp_p(dsp_p)
   );

   // Slice model: A0/A1, B0/B1, M, OPMODE and P registers, sync reset over CE.
   logic signed [17:0] a0, a1, b0, b1;
   logic signed [35:0] m;
   logic signed [47:0] p;
   logic [7:0]         opm_r;
   assign dsp_p = p;

   always @(posedge clk) begin
      if (dsp_rst) begin
         a0 <= '0; a1 <= '0; b0 <= '0; b1 <= '0; m <= '0; p <= '0; opm_r <= '0;
      end else if (dsp_ce) begin
         a0 <= dsp_a; a1 <= a0;
         b0 <= dsp_b; b1 <= b0;
         m  <= 36'(a1) * 36'(b1);
         opm_r <= dsp_opmode;
         case (opm_r)
            8'h01:   p <= 48'(m);
            8'h09:   p <= p + 48'(m);
            default: p <= p;
         endcase
      end
   end

   typedef struct packed {
      logic [7:0]       len;
      logic [3:0][17:0] a;
      logic [3:0][17:0] b;
      logic [7:0]       gap;
      logic [7:0]       hold;
      logic [47:0]      exp;
   } job_t;

   job_t        jobs[5];
   logic [47:0] exp_q[$];
   int          n_checks = 0;
   int          n_pass   = 0;

   task automatic check(input bit ok, input string name, input logic [47:0] act, input logic [47:0] req);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, $signed(act), act, $signed(req), req);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_beat(input int j, input int i, input int av, input int bv);
      jobs[j].a[i] = 18'(av);
      jobs[j].b[i] = 18'(bv);
   endtask

   // Result port scoreboard: each handshake consumes the oldest expected sum.
   always @(negedge clk) begin
      if (res_valid === 1'b1 && res_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_result", result, 48'd0);
         end else begin
            logic [47:0] e;
            e = exp_q.pop_front();
            check(result === e, "result", result, e);
         end
      end
   end

   task automatic start_job(input logic [7:0] l, input logic [47:0] e, input bit push);
      start = 1'b1;
      len   = l;
      if (push) exp_q.push_back(e);
      tick();
      start = 1'b0;
      len   = 8'hAA;
   endtask

   task automatic feed(input job_t j, input int n);
      for (int i = 0; i < n; i++) begin
         for (int g = 0; g < int'(j.gap); g++) begin
            s_valid = 1'b0;
            s_a     = 18'sd1234;
            s_b     = -18'sd77;
            @(negedge clk);
            check(dsp_ce === 1'b0 && dsp_a === 18'sd0, "gap_ce_low", {47'd0, dsp_ce}, 48'd0);
            tick();
         end
         s_valid = 1'b1;
         s_a     = j.a[i];
         s_b     = j.b[i];
         @(negedge clk);
         check(s_ready === 1'b1 && dsp_ce === 1'b1 && dsp_a === j.a[i], "beat_drive",
               48'(dsp_a), 48'(j.a[i]));
         tick();
      end
      s_valid = 1'b0;
      s_a     = '0;
      s_b     = '0;
   endtask

   // Called just after the edge accepting the last beat; counts the edges that follow.
   task automatic wait_valid();
      int n = 0;
      while (res_valid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check(n == 4, "res_valid_latency", 48'(n), 48'd4);
   endtask

   task automatic finish_result(input int hold, input logic [47:0] e);
      res_ready = 1'b0;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check(res_valid === 1'b1 && result === e, "result_held", result, e);
         tick();
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      @(negedge clk);
      check(res_valid === 1'b0 && busy === 1'b0, "released_to_idle", {47'd0, res_valid}, 48'd0);
      tick();
   endtask

   initial begin
      RST_N = 1'b0; start = 1'b0; len = '0; s_valid = 1'b0;
      s_a = '0; s_b = '0; res_ready = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      check(busy === 1'b0 && s_ready === 1'b0, "reset_busy_ready", {46'd0, busy, s_ready}, 48'd0);
      check(res_valid === 1'b0 && result === 48'sd0, "reset_result", result, 48'd0);
      check(dsp_rst === 1'b1, "reset_dsp_rst", {47'd0, dsp_rst}, 48'd1);
      check(dsp_ce === 1'b0, "reset_dsp_ce", {47'd0, dsp_ce}, 48'd0);
      RST_N = 1'b1;
      tick();
      tick();
      check(dsp_rst === 1'b0, "dsp_rst_release", {47'd0, dsp_rst}, 48'd0);

      jobs[0] = '{len: 8'd3, a: '0, b: '0, gap: 8'd0, hold: 8'd0, exp: 48'sd480};
      set_beat(0, 0, 2, 15); set_beat(0, 1, 11, 42); set_beat(0, 2, 3, -4);
      jobs[1] = jobs[0];
      jobs[1].gap = 8'd2;
      jobs[2] = '{len: 8'd2, a: '0, b: '0, gap: 8'd1, hold: 8'd1, exp: 48'sd17179607040};
      set_beat(2, 0, 131071, 131071); set_beat(2, 1, -1, 1);
      jobs[3] = '{len: 8'd4, a: '0, b: '0, gap: 8'd0, hold: 8'd3, exp: 48'sd68719476736};
      for (int i = 0; i < 4; i++) set_beat(3, i, -131072, -131072);
      jobs[4] = '{len: 8'd1, a: '0, b: '0, gap: 8'd0, hold: 8'd0, exp: -48'sd35};
      set_beat(4, 0, -5, 7);

      for (int k = 0; k < 4; k++) begin
         start_job(jobs[k].len, jobs[k].exp, 1'b1);
         feed(jobs[k], int'(jobs[k].len));
         wait_valid();
         finish_result(int'(jobs[k].hold), jobs[k].exp);
      end

      // Zero-length job completes on the next edge without touching the slice.
      @(negedge clk);
      check(dsp_ce === 1'b0, "len0_ce_before", {47'd0, dsp_ce}, 48'd0);
      start_job(8'd0, 48'd0, 1'b1);
      check(res_valid === 1'b1 && result === 48'sd0, "len0_result", result, 48'd0);
      @(negedge clk);
      check(dsp_ce === 1'b0, "len0_ce_after", {47'd0, dsp_ce}, 48'd0);
      finish_result(0, 48'd0);

      // Back-to-back: new job requested in the result handshake cycle.
      start_job(jobs[0].len, jobs[0].exp, 1'b1);
      feed(jobs[0], 3);
      wait_valid();
      res_ready = 1'b1; start = 1'b1; len = 8'd1;
      exp_q.push_back(jobs[4].exp);
      tick();
      res_ready = 1'b0; start = 1'b0; len = 8'hAA;
      check(busy === 1'b1 && s_ready === 1'b1 && res_valid === 1'b0, "b2b_feed",
            {45'd0, busy, s_ready, res_valid}, 48'd6);
      feed(jobs[4], 1);
      wait_valid();
      finish_result(0, jobs[4].exp);

      // Reset one cycle after the second beat drops the job entirely.
      start_job(jobs[0].len, 48'd0, 1'b0);
      feed(jobs[0], 2);
      RST_N = 1'b0;
      tick();
      RST_N = 1'b1;
      check(busy === 1'b0 && s_ready === 1'b0 && res_valid === 1'b0, "midjob_reset",
            {45'd0, busy, s_ready, res_valid}, 48'd0);
      check(dsp_rst === 1'b1, "midjob_dsp_rst", {47'd0, dsp_rst}, 48'd1);
      begin
         bit seen = 1'b0;
         for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (res_valid !== 1'b0) seen = 1'b1;
         end
         check(!seen, "dropped_no_result", {47'd0, seen}, 48'd0);
      end
      tick();
      start_job(jobs[0].len, jobs[0].exp, 1'b1);
      feed(jobs[0], 3);
      wait_valid();
      finish_result(0, jobs[0].exp);

      check(exp_q.size() == 0, "scoreboard_drained", 48'(exp_q.size()), 48'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Time limit so a stuck handshake still ends the run with a summary.
   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $display("%0d/%0d checks passed", n_pass, n_checks + 1);
      $fatal(1, "timeout");
   end

endmodule
